aes_key_schedule: RTL and testbench

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_type_pkg.sv | 52 +++++
 rtl/aes_sub_word.sv | 55 +++++
 rtl/aes_key_schedule.sv | 162 ++++++++++++++++
 tb/tb_aes_key_schedule.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_type_pkg.sv
// Shared AES key-schedule types: key length encoding, FSM states,
// Nk/Nr lookups and the round-constant table.
package aes_type_pkg;

   typedef enum logic [1:0] {
      KEY_128  = 2'b00,
      KEY_192  = 2'b01,
      KEY_256  = 2'b10,
      KEY_RSVD = 2'b11
   } key_len_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GEN,
      ST_HOLD
   } ks_state_e;

   // Rcon[1..10] high bytes; entry k holds Rcon[k+1]
   localparam logic [7:0] RCON [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Key length in 32-bit words (0 for the reserved encoding)
   function automatic logic [3:0] nk_of(key_len_e len);
      case (len)
         KEY_128: return 4'd4;
         KEY_192: return 4'd6;
         KEY_256: return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   // Number of rounds (0 for the reserved encoding)
   function automatic logic [3:0] nr_of(key_len_e len);
      case (len)
         KEY_128: return 4'd10;
         KEY_192: return 4'd12;
         KEY_256: return 4'd14;
         default: return 4'd0;
      endcase
   endfunction

   // Rcon[idx] for idx in 1..10, zero elsewhere
   function automatic logic [7:0] rcon_of(logic [3:0] idx);
      logic [3:0] k;
      if (idx == 4'd0 || idx > 4'd10) return 8'h00;
      k = idx - 4'd1;
      return RCON[k];
   endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel AES S-box lookups, purely combinational.
// The S-box is computed as GF(2^8) inversion followed by the affine map.
module aes_sub_word (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   function automatic logic [7:0] xtime(logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 == a^-1 (and maps 0 to 0)
   function automatic logic [7:0] gf_inv(logic [7:0] a);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      return gf_mul(x252, x2);
   endfunction

   function automatic logic [7:0] sbox(logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
               ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   // Byte-wise substitution of the input word
   always_comb begin
      word_o = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
      end
   end

endmodule

// File: rtl/aes_key_schedule.sv
// AES key expansion (128/192/256) producing one 32-bit word per cycle and
// presenting each 128-bit round key with a valid/ready handshake.
module aes_key_schedule
   import aes_type_pkg::*;
#(
   parameter int unsigned MAX_KEY_BITS = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [MAX_KEY_BITS-1:0] key_i,
   input  logic [1:0]              key_len_i,
   input  logic                    start_i,
   input  logic                    key_ready_i,
   output logic [127:0]            key_o,
   output logic                    key_valid_o,
   output logic [3:0]              round_o,
   output logic                    last_o,
   output logic                    busy_o,
   output logic                    err_o
);

   ks_state_e    state_q, state_d;
   logic [31:0]  win_q [8];
   logic [31:0]  asm_q [3];
   logic [1:0]   asm_cnt_q;
   logic [5:0]   word_cnt_q;
   logic [2:0]   pos_q;
   logic [3:0]   rcon_idx_q;
   logic [3:0]   nk_q, nr_q, round_q;
   logic [127:0] key_q;
   logic         err_q;

   key_len_e     len_req;
   logic [3:0]   nk_req, nr_req;
   logic         start_ok;
   logic [255:0] key_pad;
   logic [31:0]  load_win [8];

   logic [2:0]   oldest_idx;
   logic [31:0]  prev_w, old_w, sub_in, sub_out, temp_w, new_w;

   assign key_pad = 256'(key_i) << (256 - MAX_KEY_BITS);

   // Decode the requested key length and check it against the build width
   always_comb begin
      len_req  = key_len_e'(key_len_i);
      nk_req   = nk_of(len_req);
      nr_req   = nr_of(len_req);
      start_ok = (len_req != KEY_RSVD) && ({nk_req, 5'd0} <= 9'(MAX_KEY_BITS));
   end

   // Window preload: key word j sits at slot Nk-1-j, so the first Nk cycles
   // simply rotate the oldest slot back in and emit the key words in order.
   always_comb begin
      for (int unsigned j = 0; j < 8; j++) load_win[j] = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         if (j < 32'(nk_req)) begin
            load_win[3'(32'(nk_req) - 32'd1 - j)] = key_pad[255-32*j -: 32];
         end
      end
   end

   // SubWord input: rotated for the i mod Nk == 0 case, plain otherwise
   always_comb begin
      prev_w = win_q[0];
      sub_in = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
   end

   aes_sub_word u_sub_word (
      .word_i (sub_in),
      .word_o (sub_out)
   );

   // Next schedule word: w[i] = w[i-Nk] ^ temp, or the raw key word for i < Nk
   always_comb begin
      oldest_idx = nk_q[2:0] - 3'd1;
      old_w      = win_q[oldest_idx];
      temp_w     = win_q[0];
      if (pos_q == 3'd0) begin
         temp_w = sub_out ^ {rcon_of(rcon_idx_q), 24'h000000};
      end else if (nk_q == 4'd8 && pos_q == 3'd4) begin
         temp_w = sub_out;
      end
      new_w = (word_cnt_q < {2'b00, nk_q}) ? old_w : (old_w ^ temp_w);
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next state; a start always wins over a same-edge transfer
   always_comb begin
      state_d = state_q;
      if (start_i) begin
         state_d = start_ok ? ST_GEN : ST_IDLE;
      end else begin
         case (state_q)
            ST_GEN:  if (asm_cnt_q == 2'd3) state_d = ST_HOLD;
            ST_HOLD: if (key_ready_i) state_d = (round_q == nr_q) ? ST_IDLE : ST_GEN;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath: key load, word generation/window shift, assembly, round count
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned j = 0; j < 8; j++) win_q[j] <= '0;
         for (int unsigned j = 0; j < 3; j++) asm_q[j] <= '0;
         asm_cnt_q  <= '0;
         word_cnt_q <= '0;
         pos_q      <= '0;
         rcon_idx_q <= '0;
         nk_q       <= '0;
         nr_q       <= '0;
         round_q    <= '0;
         key_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (start_i) begin
            if (start_ok) begin
               for (int unsigned j = 0; j < 8; j++) win_q[j] <= load_win[j];
               nk_q       <= nk_req;
               nr_q       <= nr_req;
               word_cnt_q <= '0;
               pos_q      <= '0;
               rcon_idx_q <= '0;
               asm_cnt_q  <= '0;
               round_q    <= '0;
            end else begin
               err_q <= 1'b1;
            end
         end else if (state_q == ST_GEN) begin
            win_q[0] <= new_w;
            for (int unsigned j = 1; j < 8; j++) win_q[j] <= win_q[j-1];
            word_cnt_q <= word_cnt_q + 6'd1;
            if (pos_q == oldest_idx) begin
               pos_q      <= '0;
               rcon_idx_q <= rcon_idx_q + 4'd1;
            end else begin
               pos_q <= pos_q + 3'd1;
            end
            asm_cnt_q <= asm_cnt_q + 2'd1;
            if (asm_cnt_q == 2'd3) key_q <= {asm_q[0], asm_q[1], asm_q[2], new_w};
            else                   asm_q[asm_cnt_q] <= new_w;
         end else if (state_q == ST_HOLD && key_ready_i && round_q != nr_q) begin
            round_q <= round_q + 4'd1;
         end
      end
   end

   assign key_o       = key_q;
   assign key_valid_o = (state_q == ST_HOLD);
   assign round_o     = round_q;
   assign last_o      = (state_q == ST_HOLD) && (round_q == nr_q);
   assign busy_o      = (state_q != ST_IDLE);
   assign err_o       = err_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a behavioural FIPS-197
// key expansion model with randomized keys, lengths and backpressure.
module tb_aes_key_schedule;

   logic         clk = 1'b0;
   logic         rst_n_i;
   logic [255:0] key_i;
   logic [1:0]   key_len_i;
   logic         start_i;
   logic         key_ready_i;
   logic [127:0] key_o;
   logic         key_valid_o;
   logic [3:0]   round_o;
   logic         last_o;
   logic         busy_o;
   logic         err_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  sbox_tab [256];
   logic [31:0] mw [60];

   always #5 clk = ~clk;

   aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n_i),
      .key_i       (key_i),
      .key_len_i   (key_len_i),
      .start_i     (start_i),
      .key_ready_i (key_ready_i),
      .key_o       (key_o),
      .key_valid_o (key_valid_o),
      .round_o     (round_o),
      .last_o      (last_o),
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Carry-less multiply, then reduce modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [15:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
      return prod[7:0];
   endfunction

   // S-box by brute-force inverse search and the bitwise affine formula
   task automatic build_sbox();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         end
         sbox_tab[x] = s;
      end
   endtask

   function automatic logic [31:0] subw(logic [31:0] w);
      return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
   endfunction

   task automatic model_expand(input logic [255:0] k, input logic [1:0] len);
      int nk, total;
      logic [31:0] t;
      logic [7:0] rc;
      nk    = 4 + 2 * int'(len);
      total = 4 * (nk + 7);
      rc    = 8'h01;
      for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < total; i++) begin
         t = mw[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         mw[i] = mw[i-nk] ^ t;
      end
   endtask

   // Pulse start for one edge; afterwards key/len inputs carry junk
   task automatic do_start(input logic [255:0] k, input logic [1:0] len);
      key_i     = k;
      key_len_i = len;
      start_i   = 1'b1;
      @(negedge clk);
      start_i   = 1'b0;
      key_i     = {8{$urandom()}};
      key_len_i = 2'($urandom_range(0, 3));
   endtask

   task automatic check_rounds(input logic [255:0] k, input logic [1:0] len, input int stop_at,
                               input int stall_r, input int stall_n, input bit rnd,
                               output logic [127:0] last_key);
      int nr, waited, hold;
      logic [127:0] exp;
      last_key = '0;
      model_expand(k, len);
      nr = 10 + 2 * int'(len);
      for (int r = 0; r <= nr; r++) begin
         waited = 0;
         while (!key_valid_o && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         check_eq("latency", 128'(waited), 128'd4);
         if (!key_valid_o) return;
         exp = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
         check_eq("key", key_o, exp);
         check_eq("round", 128'(round_o), 128'(r));
         check_eq("last", 128'(last_o), 128'(r == nr));
         key_ready_i = 1'b0;
         if (r == stop_at) return;
         hold = (r == stall_r) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
         repeat (hold) begin
            @(negedge clk);
            check_eq("stall_key", key_o, exp);
            check_eq("stall_round", 128'(round_o), 128'(r));
            check_eq("stall_valid", 128'(key_valid_o), 128'd1);
         end
         key_ready_i = 1'b1;
         last_key = key_o;
         @(negedge clk);
         key_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      check_eq("done_busy", 128'(busy_o), 128'd0);
      check_eq("done_valid", 128'(key_valid_o), 128'd0);
   endtask

   initial begin
      logic [127:0] lk;
      logic [255:0] rk;
      logic [1:0]   rl;
      rst_n_i = 1'b0; key_i = '0; key_len_i = '0; start_i = 1'b0; key_ready_i = 1'b0;
      build_sbox();
      repeat (3) @(negedge clk);
      check_eq("rst_key", key_o, 128'd0);
      check_eq("rst_valid", 128'(key_valid_o), 128'd0);
      check_eq("rst_round", 128'(round_o), 128'd0);
      check_eq("rst_last", 128'(last_o), 128'd0);
      check_eq("rst_busy", 128'(busy_o), 128'd0);
      check_eq("rst_err", 128'(err_o), 128'd0);
      rst_n_i = 1'b1;
      @(negedge clk);

      // AES-128 known vector, ready held high
      key_ready_i = 1'b1;
      do_start({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00);
      check_rounds({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00, -1, -1, 0, 1'b0, lk);
      check_eq("aes128_r10", lk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // AES-192 known vector with 7-cycle backpressure at r=3
      do_start({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'b01);
      check_rounds({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'b01,
                   -1, 3, 7, 1'b0, lk);
      check_eq("aes192_r12", lk, 128'he98ba06f448c773c8ecc720401002202);

      // AES-256 known vector with random backpressure
      do_start(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'b10);
      check_rounds(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'b10,
                   -1, -1, 0, 1'b1, lk);
      check_eq("aes256_r14", lk, 128'hfe4890d1e6188d0b046df344706c631e);

      // Restart at r=5, start coinciding with a transfer
      rk = {8{$urandom()}};
      do_start(rk, 2'b10);
      check_rounds(rk, 2'b10, 5, -1, 0, 1'b0, lk);
      key_ready_i = 1'b1;
      rk = {8{$urandom()}};
      do_start(rk, 2'b00);
      check_eq("abort_valid", 128'(key_valid_o), 128'd0);
      check_rounds(rk, 2'b00, -1, -1, 0, 1'b0, lk);

      // Asynchronous reset in the middle of generation
      do_start({8{$urandom()}}, 2'b01);
      @(negedge clk);
      #2 rst_n_i = 1'b0;
      #1;
      check_eq("mrst_key", key_o, 128'd0);
      check_eq("mrst_valid", 128'(key_valid_o), 128'd0);
      check_eq("mrst_round", 128'(round_o), 128'd0);
      check_eq("mrst_last", 128'(last_o), 128'd0);
      check_eq("mrst_busy", 128'(busy_o), 128'd0);
      check_eq("mrst_err", 128'(err_o), 128'd0);
      @(negedge clk);
      rst_n_i = 1'b1;
      repeat (6) @(negedge clk);
      check_eq("mrst_idle_busy", 128'(busy_o), 128'd0);
      check_eq("mrst_idle_valid", 128'(key_valid_o), 128'd0);

      // Reserved key length is rejected
      do_start({8{$urandom()}}, 2'b11);
      check_eq("ill_err", 128'(err_o), 128'd1);
      check_eq("ill_busy", 128'(busy_o), 128'd0);
      @(negedge clk);
      check_eq("ill_err_end", 128'(err_o), 128'd0);
      check_eq("ill_busy_end", 128'(busy_o), 128'd0);

      // Random keys and lengths with random handshake
      for (int n = 0; n < 4; n++) begin
         rk = {8{$urandom()}};
         rl = 2'($urandom_range(0, 2));
         do_start(rk, rl);
         check_rounds(rk, rl, -1, -1, 0, 1'b1, lk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
